// File: rtl/sr_instr_encoder_pkg.sv
// Shared constants for the schoolRISCV instruction encoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Holds the RV32I opcode/funct fields used by the subset, the 4-bit encoder
// operation codes presented on in_op, and the err_code values.
package sr_instr_encoder_pkg;

    // RV32I major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // funct3 / funct7 fields
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [6:0] F7_ADD  = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    // Encoder operation codes (in_op); 10..15 are illegal
    localparam logic [3:0] ENC_ADD  = 4'd0;
    localparam logic [3:0] ENC_OR   = 4'd1;
    localparam logic [3:0] ENC_SRL  = 4'd2;
    localparam logic [3:0] ENC_SLTU = 4'd3;
    localparam logic [3:0] ENC_SUB  = 4'd4;
    localparam logic [3:0] ENC_ADDI = 4'd5;
    localparam logic [3:0] ENC_LUI  = 4'd6;
    localparam logic [3:0] ENC_BEQ  = 4'd7;
    localparam logic [3:0] ENC_BNE  = 4'd8;
    localparam logic [3:0] ENC_JAL  = 4'd9;

    // err_code values
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_RANGE   = 2'd2;
    localparam logic [1:0] ERR_ALIGN   = 2'd3;

    function automatic logic isLegalOp(input logic [3:0] op);
        return op <= ENC_JAL;
    endfunction

endpackage

// File: rtl/sr_imm_pack.sv
// Immediate packer: scatters the op's immediate/offset into RV32I bit positions and checks range/alignment.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
//
// Ports: op (encoder op code), imm (raw in_imm), addrQ (address of the word being built),
//        immField (immediate bits in place, zero elsewhere), ok (immediate usable),
//        cause (ERR_RANGE / ERR_ALIGN when !ok, ERR_NONE otherwise).
module sr_imm_pack
    import sr_instr_encoder_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] imm,
    input  logic [31:0] addrQ,
    output logic [31:0] immField,
    output logic        ok,
    output logic [1:0]  cause
);

    logic [31:0] off;
    logic        addiFits;
    logic        brFits;
    logic        jalFits;

    // Branch/jump targets are absolute; the instruction wants PC-relative.
    assign off = imm - addrQ;

    // A value fits an N-bit signed field when every bit above the sign bit
    // equals the sign bit. Odd values inside the range are caught by the
    // separate alignment test, so range is checked on the full signed width.
    assign addiFits = (imm[31:11] == {21{imm[11]}});
    assign brFits   = (off[31:12] == {20{off[12]}});
    assign jalFits  = (off[31:20] == {12{off[20]}});

    always_comb begin
        immField = '0;
        ok       = 1'b1;
        cause    = ERR_NONE;
        case (op)
            ENC_ADDI: begin
                immField = {imm[11:0], 20'b0};
                if (!addiFits) begin
                    ok    = 1'b0;
                    cause = ERR_RANGE;
                end
            end
            ENC_LUI: begin
                immField = {imm[31:12], 12'b0};
                // Low bits cannot be represented by LUI at all.
                if (imm[11:0] != 12'b0) begin
                    ok    = 1'b0;
                    cause = ERR_ALIGN;
                end
            end
            ENC_BEQ, ENC_BNE: begin
                immField = {off[12], off[10:5], 13'b0, off[4:1], off[11], 7'b0};
                if (!brFits) begin
                    ok    = 1'b0;
                    cause = ERR_RANGE;
                end else if (off[0]) begin
                    ok    = 1'b0;
                    cause = ERR_ALIGN;
                end
            end
            ENC_JAL: begin
                immField = {off[20], off[10:1], off[11], off[19:12], 12'b0};
                if (!jalFits) begin
                    ok    = 1'b0;
                    cause = ERR_RANGE;
                end else if (off[0]) begin
                    ok    = 1'b0;
                    cause = ERR_ALIGN;
                end
            end
            default: begin
                // R-type and illegal ops carry no immediate.
            end
        endcase
    end

endmodule

// File: rtl/sr_instr_encoder.sv
// Encodes symbolic schoolRISCV requests into RV32I words tagged with their instruction address.
// Latency: 1 cycle from accept to out_valid (single output register, full throughput).
// Backpressure: in_ready = !out_valid | out_ready; output holds stable while stalled.
//
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_op/in_rd/in_rs1/in_rs2/in_imm request;
//        out_valid/out_ready/out_instr/out_addr encoded word; err (sticky), err_code (last drop
//        cause), err_count (saturating drop count).
module sr_instr_encoder
    import sr_instr_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [7:0]  err_count
);

    logic [31:0] addrQ;
    logic        outValidQ;
    logic [31:0] outInstrQ;
    logic [31:0] outAddrQ;
    logic        errQ;
    logic [1:0]  errCodeQ;
    logic [7:0]  errCountQ;

    logic [31:0] immField;
    logic        immOk;
    logic [1:0]  immCause;
    logic [31:0] baseWord;
    logic        opLegal;
    logic        reqLegal;
    logic [1:0]  dropCode;
    logic        accept;

    sr_imm_pack uImmPack (
        .op       (in_op),
        .imm      (in_imm),
        .addrQ    (addrQ),
        .immField (immField),
        .ok       (immOk),
        .cause    (immCause)
    );

    // Non-immediate fields of each format; immediate slots left zero so the
    // packed immediate can simply be OR-ed in.
    always_comb begin
        baseWord = '0;
        case (in_op)
            ENC_ADD:  baseWord = {F7_ADD, in_rs2, in_rs1, F3_ADD,  in_rd, OPC_OP};
            ENC_OR:   baseWord = {F7_ADD, in_rs2, in_rs1, F3_OR,   in_rd, OPC_OP};
            ENC_SRL:  baseWord = {F7_ADD, in_rs2, in_rs1, F3_SRL,  in_rd, OPC_OP};
            ENC_SLTU: baseWord = {F7_ADD, in_rs2, in_rs1, F3_SLTU, in_rd, OPC_OP};
            ENC_SUB:  baseWord = {F7_SUB, in_rs2, in_rs1, F3_ADD,  in_rd, OPC_OP};
            ENC_ADDI: baseWord = {12'b0, in_rs1, F3_ADD, in_rd, OPC_OP_IMM};
            ENC_LUI:  baseWord = {20'b0, in_rd, OPC_LUI};
            ENC_BEQ:  baseWord = {7'b0, in_rs2, in_rs1, F3_BEQ, 5'b0, OPC_BRANCH};
            ENC_BNE:  baseWord = {7'b0, in_rs2, in_rs1, F3_BNE, 5'b0, OPC_BRANCH};
            ENC_JAL:  baseWord = {20'b0, in_rd, OPC_JAL};
            default:  baseWord = '0;
        endcase
    end

    // Illegal op outranks any immediate fault.
    assign opLegal  = isLegalOp(in_op);
    assign reqLegal = opLegal & immOk;
    assign dropCode = opLegal ? immCause : ERR_ILLEGAL;

    assign in_ready = !outValidQ | out_ready;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            addrQ     <= BASE_ADDR;
            outValidQ <= 1'b0;
            outInstrQ <= '0;
            outAddrQ  <= '0;
            errQ      <= 1'b0;
            errCodeQ  <= ERR_NONE;
            errCountQ <= '0;
        end else begin
            if (accept && reqLegal) begin
                outValidQ <= 1'b1;
                outInstrQ <= baseWord | immField;
                outAddrQ  <= addrQ;
                addrQ     <= addrQ + 32'd4;
            end else if (outValidQ && out_ready) begin
                // Drained with nothing legal behind it (idle or dropped request).
                outValidQ <= 1'b0;
            end

            if (accept && !reqLegal) begin
                errQ     <= 1'b1;
                errCodeQ <= dropCode;
                if (errCountQ != 8'hFF) begin
                    errCountQ <= errCountQ + 8'd1;
                end
            end
        end
    end

    assign out_valid = outValidQ;
    assign out_instr = outInstrQ;
    assign out_addr  = outAddrQ;
    assign err       = errQ;
    assign err_code  = errCodeQ;
    assign err_count = errCountQ;

endmodule
